// File: rtl/module_concat_split_pkg.sv
// module_concat_split_pkg
//   Shared types and defaults for the concat-split receive path.
//   - split_state_e : splitter FSM states
//   - DEF_*         : default word/beat/FIFO geometry
//   - beat_slice    : reference slice of a default-width word, MSB-first
package module_concat_split_pkg;

    localparam int unsigned DEF_WORD_W     = 16;
    localparam int unsigned DEF_BEAT_W     = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        IDLE,
        EMIT
    } split_state_e;

    // Beat idx of a default-geometry word; idx 0 is the most-significant slice.
    function automatic logic [DEF_BEAT_W-1:0] beat_slice(input logic [DEF_WORD_W-1:0] word,
                                                         input int unsigned           idx);
        return word[DEF_WORD_W-1-idx*DEF_BEAT_W -: DEF_BEAT_W];
    endfunction

endpackage

// File: rtl/module_concat_split_fifo.sv
// module_concat_split_fifo
//   Synchronous FIFO with push/pop/flush and a registered occupancy level.
//   Ports:
//     in_clk, in_rst   clock, synchronous active-high reset
//     in_flush         empties the FIFO next cycle; a same-cycle push is dropped
//     in_push          write in_push_data (caller guarantees not full)
//     in_push_data     data to write
//     in_pop           advance read pointer (caller guarantees not empty)
//     out_head         entry at the read pointer
//     out_level        entries currently stored
module module_concat_split_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_flush,
    input  logic             in_push,
    input  logic [WIDTH-1:0] in_push_data,
    input  logic             in_pop,
    output logic [WIDTH-1:0] out_head,
    output logic [LVL_W-1:0] out_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic push_en;
    logic pop_en;

    assign push_en = in_push && !in_flush;
    assign pop_en  = in_pop && !in_flush;

    // Storage is not reset; level/pointers define validity.
    always_ff @(posedge in_clk) begin
        if (push_en && !in_rst) begin
            mem_q[wr_ptr_q] <= in_push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge in_clk) begin
        if (in_rst || in_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign out_head  = mem_q[rd_ptr_q];
    assign out_level = level_q;

endmodule

// File: rtl/module_concat_split.sv
// module_concat_split
//   Buffers packed WORD_W-bit words ({a[3:0], b[3:0], c[7:0]} by default) and
//   emits each as BEATS beats of BEAT_W bits, most-significant slice first.
//   Ports:
//     in_clk, in_rst                    clock, synchronous active-high reset
//     in_flush                          drop FIFO contents and any word in flight
//     in_word_valid/out_word_ready/in_word      word input handshake
//     out_beat_valid/in_beat_ready/out_beat     beat output handshake
//     out_beat_idx, out_beat_last       position of the current beat in its word
//     out_beat_parity                   even parity of out_beat (0 unless enabled)
//     out_fifo_level                    words buffered, excluding the splitter
//   Build option: define CONCAT_SPLIT_PARITY_EN to generate out_beat_parity.
module module_concat_split
    import module_concat_split_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned BEAT_W     = DEF_BEAT_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned BEATS = WORD_W / BEAT_W,
    localparam int unsigned IDX_W = $clog2(BEATS),
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_flush,
    input  logic              in_word_valid,
    output logic              out_word_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_beat_valid,
    input  logic              in_beat_ready,
    output logic [BEAT_W-1:0] out_beat,
    output logic [IDX_W-1:0]  out_beat_idx,
    output logic              out_beat_last,
    output logic              out_beat_parity,
    output logic [LVL_W-1:0]  out_fifo_level
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    split_state_e      state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;

    logic              push;
    logic              pop;
    logic              beat_accept;
    logic              fifo_nonempty;
    logic [WORD_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;

    // Ready comes from the registered level only, so a same-cycle pop never opens it.
    assign out_word_ready = (fifo_level < DEPTH_LVL);
    assign push           = in_word_valid && out_word_ready && !in_flush;
    assign beat_accept    = valid_q && in_beat_ready;
    assign fifo_nonempty  = (fifo_level != '0);

    module_concat_split_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_flush     (in_flush),
        .in_push      (push),
        .in_push_data (in_word),
        .in_pop       (pop),
        .out_head     (fifo_head),
        .out_level    (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (beat_accept) begin
                    if (idx_q == LAST_IDX) begin
                        if (fifo_nonempty) begin
                            // Back-to-back load keeps one beat per clock.
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            idx_d   = '0;
                        end else begin
                            shift_d = '0;
                            idx_d   = '0;
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = {shift_q[WORD_W-BEAT_W-1:0], {BEAT_W{1'b0}}};
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (in_flush) begin
            pop     = 1'b0;
            shift_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Shift register is zeroed whenever no beat is valid, so outputs idle at 0.
    assign out_beat_valid = valid_q;
    assign out_beat       = shift_q[WORD_W-1 -: BEAT_W];
    assign out_beat_idx   = idx_q;
    assign out_beat_last  = valid_q && (idx_q == LAST_IDX);
    assign out_fifo_level = fifo_level;

`ifdef CONCAT_SPLIT_PARITY_EN
    logic parity_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^shift_d[WORD_W-1 -: BEAT_W];
        end
    end

    assign out_beat_parity = parity_q;
`else
    assign out_beat_parity = 1'b0;
`endif

endmodule

// File: tb/tb_module_concat_split.sv
// tb_module_concat_split
//   Directed checks of module_concat_split at default geometry (16/8, depth 4).
//   Parity expectations follow CONCAT_SPLIT_PARITY_EN.
module tb_module_concat_split;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_flush;
    logic        in_word_valid;
    logic        out_word_ready;
    logic [15:0] in_word;
    logic        out_beat_valid;
    logic        in_beat_ready;
    logic [7:0]  out_beat;
    logic [0:0]  out_beat_idx;
    logic        out_beat_last;
    logic        out_beat_parity;
    logic [2:0]  out_fifo_level;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 in_clk = ~in_clk;

    module_concat_split dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_flush        (in_flush),
        .in_word_valid   (in_word_valid),
        .out_word_ready  (out_word_ready),
        .in_word         (in_word),
        .out_beat_valid  (out_beat_valid),
        .in_beat_ready   (in_beat_ready),
        .out_beat        (out_beat),
        .out_beat_idx    (out_beat_idx),
        .out_beat_last   (out_beat_last),
        .out_beat_parity (out_beat_parity),
        .out_fifo_level  (out_fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    logic [7:0]  beats[$];
    logic [15:0] w2[4]  = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    logic [7:0]  e2[8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [15:0] w3[6]  = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C};
    logic [7:0]  e3[12] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6,
                            8'h07, 8'h18, 8'h29, 8'h3A, 8'h4B, 8'h5C};
    logic        exp_par_07;

    initial begin
        int first;
        int last;
        `ifdef CONCAT_SPLIT_PARITY_EN
        exp_par_07 = 1'b1;
        `else
        exp_par_07 = 1'b0;
        `endif

        in_rst = 1'b1; in_flush = 1'b0; in_word_valid = 1'b0; in_word = '0;
        in_beat_ready = 1'b0;
        step(); step();
        check("rst_valid", out_beat_valid, 0);
        check("rst_ready", out_word_ready, 1);
        check("rst_level", out_fifo_level, 0);
        check("rst_beat", out_beat, 0);
        check("rst_last", out_beat_last, 0);
        in_rst = 1'b0;
        step();

        // 1: single word, beat 0 valid two cycles after the push
        in_beat_ready = 1'b1;
        in_word_valid = 1'b1; in_word = 16'hA53C;
        step();
        in_word_valid = 1'b0;
        check("t1_lvl_n1", out_fifo_level, 1);
        check("t1_valid_n1", out_beat_valid, 0);
        step();
        check("t1_valid_n2", out_beat_valid, 1);
        check("t1_beat0", out_beat, 8'hA5);
        check("t1_idx0", out_beat_idx, 0);
        check("t1_last0", out_beat_last, 0);
        step();
        check("t1_beat1", out_beat, 8'h3C);
        check("t1_idx1", out_beat_idx, 1);
        check("t1_last1", out_beat_last, 1);
        step();
        check("t1_idle", out_beat_valid, 0);

        // 2: four back-to-back words, sink always ready
        first = -1; last = -1; beats.delete();
        for (int i = 0; i < 12; i++) begin
            in_word_valid = (i < 4);
            in_word = (i < 4) ? w2[i] : 16'h0;
            step();
            if (out_beat_valid) begin
                if (first < 0) first = i;
                last = i;
                beats.push_back(out_beat);
            end
        end
        in_word_valid = 1'b0;
        check("t2_first", first, 1);
        check("t2_count", beats.size(), 8);
        check("t2_nogap", last - first, 7);
        for (int k = 0; k < 8; k++) begin
            if (k < beats.size()) check("t2_beat", beats[k], e2[k]);
        end

        // 3: back-pressure fills the FIFO; sixth word waits for a pop
        in_beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_word_valid = 1'b1; in_word = w3[i];
            step();
        end
        in_word = w3[5];
        check("t3_level", out_fifo_level, 4);
        check("t3_ready", out_word_ready, 0);
        check("t3_beat", out_beat, 8'hA1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_ready", out_word_ready, 0);
            check("t3_stall_beat", out_beat, 8'hA1);
            check("t3_stall_idx", out_beat_idx, 0);
            check("t3_stall_level", out_fifo_level, 4);
        end
        in_beat_ready = 1'b1;
        beats.delete();
        for (int i = 0; i < 60 && beats.size() < 12; i++) begin
            logic accepted;
            accepted = in_word_valid && out_word_ready;
            if (out_beat_valid && in_beat_ready) beats.push_back(out_beat);
            step();
            if (accepted) in_word_valid = 1'b0;
        end
        check("t3_word6_taken", in_word_valid, 0);
        check("t3_count", beats.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < beats.size()) check("t3_beat_seq", beats[k], e3[k]);
        end
        step(); step();
        check("t3_drained", out_beat_valid, 0);

        // 4: flush mid-word with two words queued; same-cycle push discarded
        in_beat_ready = 1'b0;
        in_word_valid = 1'b1; in_word = 16'h1234; step();
        in_word = 16'h5678; step();
        in_word = 16'h9ABC; step();
        in_word_valid = 1'b0;
        check("t4_beat0", out_beat, 8'h12);
        check("t4_level_pre", out_fifo_level, 2);
        in_beat_ready = 1'b1;
        step();
        check("t4_beat1_shown", out_beat, 8'h34);
        in_beat_ready = 1'b0;
        in_flush = 1'b1; in_word_valid = 1'b1; in_word = 16'hDEAD;
        step();
        in_flush = 1'b0; in_word_valid = 1'b0;
        check("t4_flush_valid", out_beat_valid, 0);
        check("t4_flush_level", out_fifo_level, 0);
        check("t4_flush_ready", out_word_ready, 1);
        step(); step();
        check("t4_stays_idle", out_beat_valid, 0);
        in_beat_ready = 1'b1;
        in_word_valid = 1'b1; in_word = 16'h0F1E;
        step();
        in_word_valid = 1'b0;
        step();
        check("t4_restart_b0", out_beat, 8'h0F);
        check("t4_restart_i0", out_beat_idx, 0);
        step();
        check("t4_restart_b1", out_beat, 8'h1E);
        check("t4_restart_last", out_beat_last, 1);
        step();

        // 5: reset mid-EMIT with three words buffered
        in_beat_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_word_valid = 1'b1; in_word = 16'h1111 * 16'(i + 1);
            step();
        end
        in_word_valid = 1'b0;
        check("t5_level_pre", out_fifo_level, 3);
        check("t5_valid_pre", out_beat_valid, 1);
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        check("t5_valid", out_beat_valid, 0);
        check("t5_beat", out_beat, 0);
        check("t5_idx", out_beat_idx, 0);
        check("t5_last", out_beat_last, 0);
        check("t5_parity", out_beat_parity, 0);
        check("t5_level", out_fifo_level, 0);
        check("t5_ready", out_word_ready, 1);
        step();

        // 6: parity on beats 07 and 03
        in_beat_ready = 1'b1;
        in_word_valid = 1'b1; in_word = 16'h0703;
        step();
        in_word_valid = 1'b0;
        step();
        check("t6_beat0", out_beat, 8'h07);
        check("t6_par0", out_beat_parity, exp_par_07);
        step();
        check("t6_beat1", out_beat, 8'h03);
        check("t6_par1", out_beat_parity, 0);
        step();
        check("t6_idle_par", out_beat_parity, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
